// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the fetch and decode/execute stages.
//   PC_W        - byte address width
//   INST_W      - instruction word width
//   PC_STEP_DEF - default byte increment between sequential fetches
//   fetch_state_e - fetch FSM state encoding
package inst_fetch_pkg;
  localparam int PC_W        = 8;
  localparam int INST_W      = 32;
  localparam int PC_STEP_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } fetch_state_e;
endpackage

// File: rtl/inst_fetch_pc_gen.sv
// pc_gen: program counter register with sequential increment (mod 2^PC_W)
// and word-aligned redirect load. Load has priority over advance.
//   clk, rst  - clock, synchronous active-high reset
//   advance   - step PC by PC_STEP
//   load      - replace PC with load_pc (low two bits forced to zero)
//   load_pc   - redirect target
//   pc        - current PC
//   pc_next   - value PC takes at the next edge (used to preload the fetch address)
module pc_gen
  import inst_fetch_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 8'h00,
  parameter int              PC_STEP  = PC_STEP_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            advance,
  input  logic            load,
  input  logic [PC_W-1:0] load_pc,
  output logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] pc_next
);
  localparam logic [PC_W-1:0] STEP       = PC_W'(PC_STEP);
  localparam logic [PC_W-1:0] ALIGN_MASK = ~PC_W'(3);

  logic [PC_W-1:0] pc_q, pc_d;

  always_comb begin
    pc_d = pc_q;
    if (load)         pc_d = load_pc & ALIGN_MASK;
    else if (advance) pc_d = pc_q + STEP; // natural wrap at 2^PC_W
  end

  always_ff @(posedge clk) begin
    if (rst) pc_q <= RESET_PC;
    else     pc_q <= pc_d;
  end

  assign pc      = pc_q;
  assign pc_next = rst ? RESET_PC : pc_d;
endmodule

// File: rtl/inst_fetch.sv
// inst_fetch: single-outstanding instruction fetch stage.
// Issues one memory request, waits for the response, holds the instruction
// in IR until decode accepts it, then fetches the next one. A redirect
// replaces PC at once; any request in flight at that moment is discarded.
//   clk, rst                  - clock, synchronous active-high reset
//   imem_req/imem_addr        - registered one-cycle fetch request
//   imem_rvalid/imem_rdata    - memory response
//   IR/ir_pc/ir_valid/ir_ready- instruction handoff to decode/execute
//   PC                        - address of the next fetch
//   redirect_valid/redirect_pc- branch target
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 8'h00,
  parameter int              PC_STEP  = PC_STEP_DEF
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_rvalid,
  input  logic [INST_W-1:0] imem_rdata,
  output logic [INST_W-1:0] IR,
  output logic [PC_W-1:0]   ir_pc,
  output logic              ir_valid,
  input  logic              ir_ready,
  output logic [PC_W-1:0]   PC,
  input  logic              redirect_valid,
  input  logic [PC_W-1:0]   redirect_pc
);
  fetch_state_e      state_q, state_d;
  logic              drop_q, drop_d;
  logic [INST_W-1:0] ir_q, ir_d;
  logic [PC_W-1:0]   ir_pc_q, ir_pc_d;
  logic              ir_valid_q, ir_valid_d;
  logic              imem_req_q, imem_req_d;
  logic [PC_W-1:0]   imem_addr_q, imem_addr_d;
  logic              advance, load;
  logic [PC_W-1:0]   pc, pc_next;

  pc_gen #(.RESET_PC(RESET_PC), .PC_STEP(PC_STEP)) u_pc_gen (
    .clk     (clk),
    .rst     (rst),
    .advance (advance),
    .load    (load),
    .load_pc (redirect_pc),
    .pc      (pc),
    .pc_next (pc_next)
  );

  always_comb begin
    state_d    = state_q;
    drop_d     = drop_q;
    ir_d       = ir_q;
    ir_pc_d    = ir_pc_q;
    ir_valid_d = ir_valid_q;
    advance    = 1'b0;
    // Redirect is not honoured before the first fetch has been scheduled.
    load       = redirect_valid && (state_q != IDLE);
    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        // The request already on the bus goes out with the old address;
        // its response must be thrown away.
        state_d = WAIT;
        if (redirect_valid) drop_d = 1'b1;
      end
      WAIT: begin
        if (redirect_valid) begin
          if (imem_rvalid) begin
            state_d = REQ;
            drop_d  = 1'b0;
          end else begin
            drop_d  = 1'b1;
          end
        end else if (imem_rvalid) begin
          if (drop_q) begin
            state_d = REQ;
            drop_d  = 1'b0;
          end else begin
            ir_d       = imem_rdata;
            ir_pc_d    = pc;
            ir_valid_d = 1'b1;
            advance    = 1'b1;
            state_d    = HOLD;
          end
        end
      end
      HOLD: begin
        // A same-cycle ready still counts as consumed; redirect just
        // prevents the instruction from lingering.
        if (redirect_valid || (ir_valid_q && ir_ready)) begin
          ir_valid_d = 1'b0;
          state_d    = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
    // Request is registered: preload it on the edge that enters REQ.
    imem_req_d  = (state_d == REQ);
    imem_addr_d = imem_req_d ? pc_next : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      drop_q      <= 1'b0;
      ir_q        <= '0;
      ir_pc_q     <= '0;
      ir_valid_q  <= 1'b0;
      imem_req_q  <= 1'b0;
      imem_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      drop_q      <= drop_d;
      ir_q        <= ir_d;
      ir_pc_q     <= ir_pc_d;
      ir_valid_q  <= ir_valid_d;
      imem_req_q  <= imem_req_d;
      imem_addr_q <= imem_addr_d;
    end
  end

  assign imem_req  = imem_req_q;
  assign imem_addr = imem_addr_q;
  assign IR        = ir_q;
  assign ir_pc     = ir_pc_q;
  assign ir_valid  = ir_valid_q;
  assign PC        = pc;
endmodule

// File: tb/tb_inst_fetch.sv
module tb_inst_fetch;
  import inst_fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] ir;
  logic [7:0]  ir_pc;
  logic        ir_valid;
  logic        ir_ready = 1'b0;
  logic [7:0]  pc;
  logic        redirect_valid = 1'b0;
  logic [7:0]  redirect_pc = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  inst_fetch dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .IR(ir), .ir_pc(ir_pc), .ir_valid(ir_valid), .ir_ready(ir_ready),
    .PC(pc), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rv, input logic [31:0] rd, input logic rdy,
                       input logic rdv, input logic [7:0] rpc);
    imem_rvalid = rv; imem_rdata = rd; ir_ready = rdy;
    redirect_valid = rdv; redirect_pc = rpc;
  endtask

  // Memory contents for the random phase: any fixed function of the address.
  function automatic logic [31:0] memf(input logic [7:0] a);
    return {a, ~a, a ^ 8'h5A, 8'hC3};
  endfunction

  typedef struct {
    logic        rv;   logic [31:0] rd; logic rdy; logic rdv; logic [7:0] rpc;
    logic        req;  logic [7:0]  addr;
    logic        irv;  logic [31:0] ir; logic [7:0] irpc; logic [7:0] pc;
  } vec_t;

  function automatic vec_t v(input logic rv, input logic [31:0] rd, input logic rdy,
                             input logic rdv, input logic [7:0] rpc, input logic req,
                             input logic [7:0] addr, input logic irv, input logic [31:0] irw,
                             input logic [7:0] irpc, input logic [7:0] pcv);
    vec_t r;
    r.rv = rv; r.rd = rd; r.rdy = rdy; r.rdv = rdv; r.rpc = rpc;
    r.req = req; r.addr = addr; r.irv = irv; r.ir = irw; r.irpc = irpc; r.pc = pcv;
    return r;
  endfunction

  vec_t tbl[29];

  // Random-phase model state
  logic [7:0]  exp_pc, out_addr, exp_irpc;
  logic [31:0] exp_ir;
  logic        out, dropped, exp_irv, first, rv, rdy, rdv;
  logic [7:0]  rpc;
  int          cnt, gap, consumed;

  initial begin
    #2000000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    // Cycle-accurate directed trace: inputs applied during the row's cycle,
    // expectations are the outputs at the start of that cycle.
    tbl[0]  = v(0, 0, 0, 0, 0,            0, 8'h00, 0, 0, 8'h00, 8'h00);
    tbl[1]  = v(0, 0, 0, 0, 0,            1, 8'h00, 0, 0, 8'h00, 8'h00);
    tbl[2]  = v(1, 32'hE0810002, 0, 0, 0, 0, 8'h00, 0, 0, 8'h00, 8'h00);
    for (int i = 3; i < 8; i++)
      tbl[i] = v(0, 0, 0, 0, 0,           0, 8'h00, 1, 32'hE0810002, 8'h00, 8'h04);
    tbl[8]  = v(0, 0, 1, 0, 0,            0, 8'h00, 1, 32'hE0810002, 8'h00, 8'h04);
    tbl[9]  = v(0, 0, 0, 0, 0,            1, 8'h04, 0, 32'hE0810002, 8'h00, 8'h04);
    tbl[10] = v(0, 0, 0, 1, 8'h43,        0, 8'h00, 0, 32'hE0810002, 8'h00, 8'h04);
    tbl[11] = v(0, 0, 0, 0, 0,            0, 8'h00, 0, 32'hE0810002, 8'h00, 8'h40);
    tbl[12] = v(1, 32'hDEADBEEF, 0, 0, 0, 0, 8'h00, 0, 32'hE0810002, 8'h00, 8'h40);
    tbl[13] = v(0, 0, 0, 0, 0,            1, 8'h40, 0, 32'hE0810002, 8'h00, 8'h40);
    tbl[14] = v(1, 32'h11111111, 0, 1, 8'hFE, 0, 8'h00, 0, 32'hE0810002, 8'h00, 8'h40);
    tbl[15] = v(0, 0, 0, 0, 0,            1, 8'hFC, 0, 32'hE0810002, 8'h00, 8'hFC);
    tbl[16] = v(1, 32'h22222222, 0, 0, 0, 0, 8'h00, 0, 32'hE0810002, 8'h00, 8'hFC);
    tbl[17] = v(0, 0, 1, 0, 0,            0, 8'h00, 1, 32'h22222222, 8'hFC, 8'h00);
    tbl[18] = v(0, 0, 0, 0, 0,            1, 8'h00, 0, 32'h22222222, 8'hFC, 8'h00);
    tbl[19] = v(1, 32'h66666666, 0, 0, 0, 0, 8'h00, 0, 32'h22222222, 8'hFC, 8'h00);
    tbl[20] = v(0, 0, 1, 1, 8'h81,        0, 8'h00, 1, 32'h66666666, 8'h00, 8'h04);
    tbl[21] = v(0, 0, 0, 0, 0,            1, 8'h80, 0, 32'h66666666, 8'h00, 8'h80);
    tbl[22] = v(1, 32'h33333333, 0, 0, 0, 0, 8'h00, 0, 32'h66666666, 8'h00, 8'h80);
    tbl[23] = v(0, 0, 1, 0, 0,            0, 8'h00, 1, 32'h33333333, 8'h80, 8'h84);
    tbl[24] = v(0, 0, 0, 1, 8'h10,        1, 8'h84, 0, 32'h33333333, 8'h80, 8'h84);
    tbl[25] = v(1, 32'h44444444, 0, 0, 0, 0, 8'h00, 0, 32'h33333333, 8'h80, 8'h10);
    tbl[26] = v(0, 0, 0, 0, 0,            1, 8'h10, 0, 32'h33333333, 8'h80, 8'h10);
    tbl[27] = v(1, 32'h55555555, 0, 0, 0, 0, 8'h00, 0, 32'h33333333, 8'h80, 8'h10);
    tbl[28] = v(0, 0, 0, 0, 0,            0, 8'h00, 1, 32'h55555555, 8'h10, 8'h14);

    // Reset state
    rst = 1'b1;
    cyc(); cyc(); cyc();
    chk("rst_req", 32'(imem_req), 0);
    chk("rst_addr", 32'(imem_addr), 0);
    chk("rst_irv", 32'(ir_valid), 0);
    chk("rst_ir", ir, 0);
    chk("rst_irpc", 32'(ir_pc), 0);
    chk("rst_pc", 32'(pc), 0);
    rst = 1'b0;

    for (int i = 0; i < 29; i++) begin
      chk($sformatf("t%0d_req", i), 32'(imem_req), 32'(tbl[i].req));
      if (tbl[i].req) chk($sformatf("t%0d_addr", i), 32'(imem_addr), 32'(tbl[i].addr));
      chk($sformatf("t%0d_irv", i), 32'(ir_valid), 32'(tbl[i].irv));
      chk($sformatf("t%0d_ir", i), ir, tbl[i].ir);
      chk($sformatf("t%0d_irpc", i), 32'(ir_pc), 32'(tbl[i].irpc));
      chk($sformatf("t%0d_pc", i), 32'(pc), 32'(tbl[i].pc));
      drive(tbl[i].rv, tbl[i].rd, tbl[i].rdy, tbl[i].rdv, tbl[i].rpc);
      cyc();
    end

    // Reset while waiting for a response, then a stale response.
    drive(0, 0, 1, 0, 0); cyc();
    chk("rw_req", 32'(imem_req), 1);
    chk("rw_addr", 32'(imem_addr), 32'h14);
    drive(0, 0, 0, 0, 0); cyc();          // now in WAIT
    rst = 1'b1; cyc();
    chk("rw_rst_irv", 32'(ir_valid), 0);
    chk("rw_rst_ir", ir, 0);
    chk("rw_rst_pc", 32'(pc), 0);
    rst = 1'b0;
    drive(1, 32'hBADC0DE0, 0, 0, 0); cyc();
    drive(0, 0, 0, 0, 0);
    chk("rw_req2", 32'(imem_req), 1);
    chk("rw_addr2", 32'(imem_addr), 0);
    chk("rw_irv2", 32'(ir_valid), 0);
    cyc();
    chk("rw_irv3", 32'(ir_valid), 0);
    chk("rw_ir3", ir, 0);

    // Randomized run against a transaction-level model.
    rst = 1'b1; cyc(); cyc(); rst = 1'b0;
    exp_pc = 8'h00; out = 0; dropped = 0; exp_irv = 0; exp_ir = 0; exp_irpc = 0;
    out_addr = 0; first = 1; cnt = 0; gap = 0; consumed = 0;
    for (int c = 0; c < 3000; c++) begin
      chk("r_pc", 32'(pc), 32'(exp_pc));
      chk("r_irv", 32'(ir_valid), 32'(exp_irv));
      if (exp_irv) begin
        chk("r_ir", ir, exp_ir);
        chk("r_irpc", 32'(ir_pc), 32'(exp_irpc));
      end
      rv = 0;
      if (imem_req) begin
        chk("r_one_outstanding", 32'(out), 0);
        chk("r_addr", 32'(imem_addr), 32'(exp_pc));
        out = 1; out_addr = imem_addr; dropped = 0;
        cnt = $urandom_range(1, 3); gap = 0;
      end else begin
        gap++;
        if (out) begin
          cnt--;
          if (cnt == 0) rv = 1;
        end
      end
      if (gap > 40) begin
        chk("r_liveness", 32'(gap), 40);
        break;
      end
      rdy = 1'($urandom_range(0, 1));
      rdv = !first && ($urandom_range(0, 9) == 0);
      rpc = 8'($urandom);
      drive(rv, rv ? memf(out_addr) : $urandom, rdy, rdv, rpc);
      // Model update for the coming edge.
      if (exp_irv && rdy) begin
        consumed++;
        exp_irv = 0;
      end
      if (rdv) begin
        exp_pc = rpc & 8'hFC;
        exp_irv = 0;
        if (out) begin
          if (rv) out = 0;
          else dropped = 1;
        end
      end else if (rv) begin
        out = 0;
        if (!dropped) begin
          exp_irv = 1; exp_ir = memf(out_addr); exp_irpc = out_addr;
          exp_pc = out_addr + 8'd4;
        end
      end
      first = 0;
      cyc();
    end
    drive(0, 0, 0, 0, 0);
    chk("r_progress", 32'(consumed > 100), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
